// File: rtl/fetch_stage.sv
// fetch_stage: owns the fetch PC, drives a 1-cycle-latency instruction memory and
// presents a registered {pc, inst} pair to decode with a one-entry skid buffer. Rev 1.0
`default_nettype none

module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          IMEM_AW  = 14
) (
  input  logic               clk,
  input  logic               rstn,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  input  logic               halt,
  output logic [31:0]        pc,
  output logic [31:0]        inst,
  output logic               valid,
  output logic               halted
);

  localparam logic [31:0] BUBBLE = 32'h0000_0001;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fpc_q, fpc_d;
  logic        ifl_v_q, ifl_v_d;
  logic [31:0] ifl_pc_q, ifl_pc_d;
  logic        skid_v_q, skid_v_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;

  // A redirect issues its target immediately; otherwise issue only when decode can accept.
  assign imem_en   = rstn && (state_q != HALT) && (redirect || !stall);
  assign imem_addr = redirect ? redirect_pc[IMEM_AW+1:2] : fpc_q[IMEM_AW+1:2];

  assign pc     = pc_q;
  assign inst   = inst_q;
  assign valid  = valid_q;
  assign halted = halted_q;

  always_comb begin
    state_d     = state_q;
    fpc_d       = fpc_q;
    ifl_v_d     = ifl_v_q;
    ifl_pc_d    = ifl_pc_q;
    skid_v_d    = skid_v_q;
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    valid_d     = valid_q;
    halted_d    = halted_q;

    if (state_q == HALT) begin
      state_d = HALT;
    end else if (redirect) begin
      inst_d   = BUBBLE;
      valid_d  = 1'b0;
      skid_v_d = 1'b0;
      ifl_v_d  = 1'b1;
      ifl_pc_d = redirect_pc;
      fpc_d    = redirect_pc + 32'd4;
      state_d  = RUN;
    end else if (stall) begin
      // The word landing this cycle would be lost without the skid entry.
      if (ifl_v_q) begin
        skid_v_d    = 1'b1;
        skid_pc_d   = ifl_pc_q;
        skid_inst_d = imem_rdata;
      end
      ifl_v_d = 1'b0;
      state_d = STALL;
    end else if (halt) begin
      inst_d   = BUBBLE;
      valid_d  = 1'b0;
      ifl_v_d  = 1'b0;
      skid_v_d = 1'b0;
      halted_d = 1'b1;
      state_d  = HALT;
    end else begin
      if (skid_v_q) begin
        pc_d    = skid_pc_q;
        inst_d  = skid_inst_q;
        valid_d = 1'b1;
      end else if (ifl_v_q) begin
        pc_d    = ifl_pc_q;
        inst_d  = imem_rdata;
        valid_d = 1'b1;
      end else begin
        inst_d  = BUBBLE;
        valid_d = 1'b0;
      end
      skid_v_d = 1'b0;
      ifl_v_d  = 1'b1;
      ifl_pc_d = fpc_q;
      fpc_d    = fpc_q + 32'd4;
      state_d  = RUN;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= RUN;
      fpc_q       <= RESET_PC;
      ifl_v_q     <= 1'b0;
      ifl_pc_q    <= 32'h0;
      skid_v_q    <= 1'b0;
      skid_pc_q   <= 32'h0;
      skid_inst_q <= 32'h0;
      pc_q        <= 32'h0;
      inst_q      <= BUBBLE;
      valid_q     <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      fpc_q       <= fpc_d;
      ifl_v_q     <= ifl_v_d;
      ifl_pc_q    <= ifl_pc_d;
      skid_v_q    <= skid_v_d;
      skid_pc_q   <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      valid_q     <= valid_d;
      halted_q    <= halted_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vector table plus hand-written corner sequences for fetch_stage.
`default_nettype none

module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rstn;
  logic        stall, redirect, halt;
  logic [31:0] redirect_pc;

  logic        imem_en, valid, halted;
  logic [13:0] imem_addr;
  logic [31:0] imem_rdata, pc, inst;

  logic        imem_en2, valid2, halted2;
  logic [13:0] imem_addr2;
  logic [31:0] imem_rdata2, pc2, inst2;
  logic        zero1 = 1'b0;
  logic [31:0] zero32 = 32'h0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0), .IMEM_AW(14)) dut (
    .clk(clk), .rstn(rstn), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .halt(halt), .pc(pc), .inst(inst),
    .valid(valid), .halted(halted)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .IMEM_AW(14)) dut_wrap (
    .clk(clk), .rstn(rstn), .imem_en(imem_en2), .imem_addr(imem_addr2),
    .imem_rdata(imem_rdata2), .stall(zero1), .redirect(zero1),
    .redirect_pc(zero32), .halt(zero1), .pc(pc2), .inst(inst2),
    .valid(valid2), .halted(halted2)
  );

  // Memory contents: word i holds 32'h2000_0000 + i, one cycle read latency.
  always @(posedge clk) begin
    if (imem_en)  imem_rdata  <= 32'h2000_0000 + {18'h0, imem_addr};
    if (imem_en2) imem_rdata2 <= 32'h2000_0000 + {18'h0, imem_addr2};
  end

  function automatic logic [31:0] word_at(input logic [31:0] p);
    return 32'h2000_0000 + {18'h0, p[15:2]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        stall;
    logic        redirect;
    logic [31:0] rpc;
    logic        exp_en;
    logic [13:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rp,
                              input logic en, input logic [13:0] ad,
                              input logic v, input logic [31:0] p, input logic [31:0] i);
    vec_t t;
    t.stall = s; t.redirect = r; t.rpc = rp; t.exp_en = en; t.exp_addr = ad;
    t.exp_valid = v; t.exp_pc = p; t.exp_inst = i;
    return t;
  endfunction

  vec_t vt[13];

  initial begin
    vt[0]  = mk(0, 0, 0,        1, 14'h000, 0, 32'h00,  32'h1);
    vt[1]  = mk(0, 0, 0,        1, 14'h001, 1, 32'h00,  word_at(32'h00));
    vt[2]  = mk(0, 0, 0,        1, 14'h002, 1, 32'h04,  word_at(32'h04));
    vt[3]  = mk(0, 0, 0,        1, 14'h003, 1, 32'h08,  word_at(32'h08));
    vt[4]  = mk(1, 0, 0,        0, 14'h000, 1, 32'h08,  word_at(32'h08));
    vt[5]  = mk(1, 0, 0,        0, 14'h000, 1, 32'h08,  word_at(32'h08));
    vt[6]  = mk(1, 0, 0,        0, 14'h000, 1, 32'h08,  word_at(32'h08));
    vt[7]  = mk(0, 0, 0,        1, 14'h004, 1, 32'h0C,  word_at(32'h0C));
    vt[8]  = mk(0, 0, 0,        1, 14'h005, 1, 32'h10,  word_at(32'h10));
    vt[9]  = mk(0, 0, 0,        1, 14'h006, 1, 32'h14,  word_at(32'h14));
    vt[10] = mk(0, 1, 32'h100,  1, 14'h040, 0, 32'h14,  32'h1);
    vt[11] = mk(0, 0, 0,        1, 14'h041, 1, 32'h100, word_at(32'h100));
    vt[12] = mk(0, 0, 0,        1, 14'h042, 1, 32'h104, word_at(32'h104));

    rstn = 1'b0; stall = 1'b0; redirect = 1'b0; halt = 1'b0; redirect_pc = 32'h0;
    #23;
    chk("reset_pc",     pc,     32'h0);
    chk("reset_inst",   inst,   32'h1);
    chk("reset_valid",  {31'h0, valid},   32'h0);
    chk("reset_halted", {31'h0, halted},  32'h0);
    chk("reset_en",     {31'h0, imem_en}, 32'h0);

    @(posedge clk); #1;
    rstn = 1'b1;

    // Streaming, 3-cycle stall at pc 8, redirect to 0x100.
    for (int i = 0; i < 13; i++) begin
      stall = vt[i].stall; redirect = vt[i].redirect; redirect_pc = vt[i].rpc;
      #1;
      chk($sformatf("v%0d_en", i), {31'h0, imem_en}, {31'h0, vt[i].exp_en});
      if (vt[i].exp_en)
        chk($sformatf("v%0d_addr", i), {18'h0, imem_addr}, {18'h0, vt[i].exp_addr});
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", i), {31'h0, valid}, {31'h0, vt[i].exp_valid});
      chk($sformatf("v%0d_pc", i),    pc,   vt[i].exp_pc);
      chk($sformatf("v%0d_inst", i),  inst, vt[i].exp_inst);
    end

    // Redirect with stall while the skid is full: redirect wins.
    stall = 1'b1; redirect = 1'b0;
    tick();
    chk("skid_hold_pc", pc, 32'h104);
    redirect = 1'b1; redirect_pc = 32'h200;
    #1;
    chk("rs_en", {31'h0, imem_en}, 32'h1);
    chk("rs_addr", {18'h0, imem_addr}, 32'h80);
    tick();
    chk("rs_bubble_valid", {31'h0, valid}, 32'h0);
    chk("rs_bubble_inst", inst, 32'h1);
    stall = 1'b0; redirect = 1'b0;
    tick();
    chk("rs_target_pc", pc, 32'h200);
    chk("rs_target_inst", inst, word_at(32'h200));
    tick();
    chk("rs_next_pc", pc, 32'h204);

    // Halt at pc 0x20.
    redirect = 1'b1; redirect_pc = 32'h20;
    tick();
    redirect = 1'b0;
    tick();
    chk("pre_halt_pc", pc, 32'h20);
    chk("pre_halt_inst", inst, word_at(32'h20));
    halt = 1'b1;
    tick();
    chk("halt_valid", {31'h0, valid}, 32'h0);
    chk("halt_inst", inst, 32'h1);
    chk("halt_halted", {31'h0, halted}, 32'h1);
    halt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      stall = i[0]; redirect = i[1]; redirect_pc = 32'h300;
      #1;
      chk($sformatf("halted_en%0d", i), {31'h0, imem_en}, 32'h0);
      tick();
      chk($sformatf("halted_flag%0d", i), {31'h0, halted}, 32'h1);
      chk($sformatf("halted_valid%0d", i), {31'h0, valid}, 32'h0);
      chk($sformatf("halted_pc%0d", i), pc, 32'h20);
    end
    stall = 1'b0; redirect = 1'b0;

    // Asynchronous reset from HALT, then restart; second instance checks PC wrap.
    #2;
    rstn = 1'b0;
    #1;
    chk("async_rst_pc", pc, 32'h0);
    chk("async_rst_halted", {31'h0, halted}, 32'h0);
    chk("async_rst_en", {31'h0, imem_en}, 32'h0);
    @(posedge clk); #1;
    rstn = 1'b1;
    tick();
    chk("restart_bubble_valid", {31'h0, valid}, 32'h0);
    chk("wrap_bubble_valid", {31'h0, valid2}, 32'h0);
    tick();
    chk("restart_pc0", pc, 32'h0);
    chk("restart_inst0", inst, word_at(32'h0));
    chk("restart_valid", {31'h0, valid}, 32'h1);
    chk("wrap_pc0", pc2, 32'hFFFF_FFF8);
    chk("wrap_inst0", inst2, word_at(32'hFFFF_FFF8));
    tick();
    chk("restart_pc1", pc, 32'h4);
    chk("wrap_pc1", pc2, 32'hFFFF_FFFC);
    chk("wrap_inst1", inst2, word_at(32'hFFFF_FFFC));
    tick();
    chk("wrap_pc2", pc2, 32'h0);
    chk("wrap_inst2", inst2, 32'h2000_0000);
    chk("wrap_valid2", {31'h0, valid2}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage that sits directly upstream of `decode`. It owns the architectural fetch PC and drives a synchronous instruction memory with 1-cycle read latency. It presents a registered `{pc, inst}` pair to `decode`, with a one-entry skid buffer so that stalls lose no fetched word. It also handles redirects from branch/jr resolution and the halt on `stop`.

## Interface
Parameters:
- `RESET_PC`, default 32'h0: fetch address after reset.
- `IMEM_AW`, default 14: instruction-memory word-address width. Word address is `pc[IMEM_AW+1:2]`.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `imem_en` out 1: read enable. It is combinational, and it is 0 while `rstn`=0.
- `imem_addr` out IMEM_AW: word address. It is combinational.
- `imem_rdata` in 32: read data, valid the cycle after `imem_en`=1.
- `stall` in 1: `decode` cannot accept; driven by decode `hazard` OR load/FPU wait.
- `redirect` in 1: discard the wrong path and fetch from `redirect_pc`.
- `redirect_pc` in 32: redirect target, word aligned.
- `halt` in 1: `decode` has a `stop` instruction. Sampled only when `stall`=0.
- `pc` out 32: PC of `inst`; goes to decode `pc`.
- `inst` out 32: instruction; goes to decode `inst`.
- `valid` out 1: `inst` is a real fetched word. When 0, `inst` = BUBBLE.
- `halted` out 1: fetch is permanently stopped.

## Operation
- BUBBLE = 32'h0000_0001, the special/funct-1 no-op. `decode` treats it as do-nothing, writes no register, and does not raise a hazard.

Internal state:
- `fpc` (32): next address to issue.
- `ifl_v`/`ifl_pc`: a read is in flight and the PC it was issued for.
- `skid_v`/`skid_pc`/`skid_inst`: one-entry skid buffer.
- FSM in {RUN, STALL, HALT}.

Issue rules (combinational):
- RUN with `stall`=0, no redirect: `imem_en`=1, `imem_addr`=`fpc[IMEM_AW+1:2]`.
- `redirect`=1 in RUN or STALL: `imem_en`=1, `imem_addr`=`redirect_pc[IMEM_AW+1:2]`.
- Otherwise (`stall`=1, or HALT): `imem_en`=0.

Edge priority (highest first):
1. HALT: all state holds; outputs stay at BUBBLE.
2. `redirect`:
   - output ← {pc unchanged, BUBBLE, valid 0}; `skid_v`←0;
   - `ifl_v`←1, `ifl_pc`←`redirect_pc`, `fpc`←`redirect_pc`+4;
   - FSM←RUN.
   - Overrides `stall` and `halt` in the same cycle.
3. `stall`=1:
   - output holds;
   - if `ifl_v`: skid←{`ifl_pc`, `imem_rdata`}, `skid_v`←1;
   - `ifl_v`←0; FSM←STALL.
4. `halt`=1 (with `stall`=0):
   - output ← BUBBLE, valid 0; `ifl_v`←0, `skid_v`←0;
   - `halted`←1; FSM←HALT.
5. Normal (`stall`=0):
   - output ← skid if `skid_v`, else {`ifl_pc`, `imem_rdata`} if `ifl_v`, else BUBBLE/valid 0;
   - `skid_v`←0; the new issue sets `ifl_v`←1, `ifl_pc`←`fpc`, `fpc`←`fpc`+4;
   - FSM←RUN.

Other rules:
- PC arithmetic is 32-bit modulo 2^32; wrap from 32'hFFFF_FFFC to 0 is legal.
- `imem_addr` silently truncates `pc` bits above `IMEM_AW+1`.
- `stall` never occurs with both `skid_v`=1 and `ifl_v`=1, because no issue happens while stalled.

## Timing
Reset values (asynchronous):
- `pc`=0, `inst`=BUBBLE, `valid`=0, `halted`=0.
- `fpc`=`RESET_PC`, `ifl_v`=0, `skid_v`=0, FSM=RUN.

Latency and throughput:
- First issue is in the first cycle after `rstn` rises. `{RESET_PC, word}` is at the output after the 2nd edge.
- Steady state: one instruction per cycle.
- Redirect asserted in cycle N: BUBBLE after edge N, target instruction after edge N+1. This is a 1-bubble penalty.
- Stall release: the skid word reaches the output on the first edge with `stall`=0, and the next word follows on the edge after. No bubble.
- `rstn` asserted mid-stall, mid-redirect or in HALT: all state returns immediately to reset values; in-flight data is dropped.

## Test plan
- Reset, memory word i = 32'h2000_0000+i, no stall: the output sequence is pc 0,4,8,… with matching words, `valid`=1 from the 2nd edge, one per cycle.
- `stall` held 3 cycles mid-stream at pc 8: output holds pc 8; the pc 12 word goes to skid; on release the outputs are 12, 16 with no duplicate and no gap.
- `redirect`=1 with `redirect_pc`=32'h100 while streaming: one BUBBLE (`valid`=0, `inst`=1), then pc 0x100, 0x104. The wrong-path word is never output.
- `redirect` and `stall` in the same cycle, with skid full: redirect wins, skid is discarded, and the target appears 2 edges later.
- `halt`=1 at pc 0x20: next output is BUBBLE, `halted`=1, `imem_en`=0 forever; `stall`/`redirect` toggles are ignored. `rstn` pulse returns to pc `RESET_PC`.
- `RESET_PC`=32'hFFFF_FFF8: pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000 (wrap).
